// File: rtl/lcd_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_responder_pkg
// Description : Opcodes, status bit positions, geometry and command decode
//               shared by the KS0108-style bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_bus_responder_pkg;

  localparam int COLS  = 64;
  localparam int PAGES = 8;

  // Instruction opcodes; DISP_ONOFF carries the on/off value in bit 0
  localparam logic [7:0] DISP_ONOFF = 8'h3E;
  localparam logic [1:0] SET_Y      = 2'b01;
  localparam logic [4:0] SET_PAGE   = 5'b10111;
  localparam logic [1:0] SET_START  = 2'b11;

  localparam int STAT_BUSY = 7;
  localparam int STAT_OFF  = 5;
  localparam int STAT_RST  = 4;

  typedef struct packed {
    logic       set_on;
    logic       on_val;
    logic       set_y;
    logic [5:0] y_val;
    logic       set_x;
    logic [2:0] x_val;
    logic       set_start;
    logic [5:0] start_val;
    logic       wr_ram;
    logic       inc_y;
  } lcd_op_t;

  function automatic lcd_op_t decode_op(input logic rw, input logic di,
                                        input logic [7:0] d);
    lcd_op_t op;
    op = '0;
    if (!rw && !di) begin
      if (d[7:1] == DISP_ONOFF[7:1]) begin
        op.set_on = 1'b1;
        op.on_val = d[0];
      end else if (d[7:6] == SET_Y) begin
        op.set_y = 1'b1;
        op.y_val = d[5:0];
      end else if (d[7:3] == SET_PAGE) begin
        op.set_x = 1'b1;
        op.x_val = d[2:0];
      end else if (d[7:6] == SET_START) begin
        op.set_start = 1'b1;
        op.start_val = d[5:0];
      end
    end else if (!rw && di) begin
      op.wr_ram = 1'b1;
      op.inc_y  = 1'b1;
    end else if (rw && di) begin
      op.inc_y = 1'b1;
    end
    return op;
  endfunction

  function automatic logic [7:0] status_byte(input logic on, input logic lcd_rst);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY] = 1'b0;
    s[STAT_OFF]  = ~on;
    s[STAT_RST]  = ~lcd_rst;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ks_chip.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ks_chip
// Description : One controller half: Y/X/START/ON registers, 8x64 byte RAM
//               and a registered backdoor read port.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ks_chip
  import lcd_bus_responder_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       panel_rst_n,
  input  logic       op_valid,
  input  lcd_op_t    op,
  input  logic [7:0] wr_data,
  output logic       disp_on,
  output logic [5:0] start_line,
  output logic [7:0] cur_data,
  input  logic [2:0] bd_page,
  input  logic [5:0] bd_col,
  output logic [7:0] bd_data
);

  logic [7:0] r_ram [0:PAGES*COLS-1];
  logic       r_on;
  logic [2:0] r_x;
  logic [5:0] r_y;
  logic [5:0] r_start;
  logic [7:0] r_bd;

  always_ff @(posedge CLK) begin
    if (!RESET || !panel_rst_n) begin
      r_on    <= 1'b0;
      r_x     <= 3'd0;
      r_y     <= 6'd0;
      r_start <= 6'd0;
    end else if (op_valid) begin
      if (op.set_on)    r_on    <= op.on_val;
      if (op.set_x)     r_x     <= op.x_val;
      if (op.set_start) r_start <= op.start_val;
      if (op.set_y)     r_y     <= op.y_val;
      else if (op.inc_y) r_y    <= r_y + 6'd1;
    end
  end

  // RAM has no reset so panel reset and system reset both leave it intact
  always_ff @(posedge CLK) begin
    if (RESET && panel_rst_n && op_valid && op.wr_ram)
      r_ram[{r_x, r_y}] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) r_bd <= 8'h00;
    else        r_bd <= r_ram[{bd_page, bd_col}];
  end

  assign disp_on    = r_on;
  assign start_line = r_start;
  assign cur_data   = r_ram[{r_x, r_y}];
  assign bd_data    = r_bd;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_responder
// Description : Dual-half KS0108-style LCD bus slave: ENABLE synchronizer,
//               command decode, read mux and backdoor RAM read.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_responder
  import lcd_bus_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LCD_ENABLE,
  input  logic       LCD_RW,
  input  logic       LCD_DI,
  input  logic       LCD_CS1,
  input  logic       LCD_CS2,
  input  logic       LCD_RST,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  input  logic       RD_HALF,
  input  logic [2:0] RD_PAGE,
  input  logic [5:0] RD_COL,
  output logic [7:0] RD_DATA,
  output logic [1:0] DISP_ON
);

  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_en_d;
  logic                   r_rw, r_di, r_cs1, r_cs2;
  logic [7:0]             r_din;
  logic [7:0]             r_dout;
  logic                   r_oe;
  logic                   r_rd_half;

  logic       w_en_s, w_rise, w_fall;
  lcd_op_t    w_op;
  logic       w_valid_l, w_valid_r;
  logic       w_on_l, w_on_r;
  logic [7:0] w_cur_l, w_cur_r, w_bd_l, w_bd_r;
  logic [5:0] w_unused_start_l, w_unused_start_r;
  logic [7:0] w_rd_byte;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_en_sync <= '0;
      r_en_d    <= 1'b0;
      r_rw      <= 1'b0;
      r_di      <= 1'b0;
      r_cs1     <= 1'b0;
      r_cs2     <= 1'b0;
      r_din     <= 8'h00;
    end else begin
      r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], LCD_ENABLE};
      r_en_d    <= w_en_s;
      if (w_en_s) begin
        r_rw  <= LCD_RW;
        r_di  <= LCD_DI;
        r_cs1 <= LCD_CS1;
        r_cs2 <= LCD_CS2;
        r_din <= LCD_DATA_IN;
      end
    end
  end

  assign w_en_s    = r_en_sync[SYNC_STAGES-1];
  assign w_rise    = w_en_s & ~r_en_d;
  assign w_fall    = ~w_en_s & r_en_d;
  assign w_op      = decode_op(r_rw, r_di, r_din);
  assign w_valid_l = w_fall & r_cs1 & LCD_RST;
  assign w_valid_r = w_fall & r_cs2 & LCD_RST;

  lcd_ks_chip u_left (
    .CLK        (CLK),
    .RESET      (RESET),
    .panel_rst_n(LCD_RST),
    .op_valid   (w_valid_l),
    .op         (w_op),
    .wr_data    (r_din),
    .disp_on    (w_on_l),
    .start_line (w_unused_start_l),
    .cur_data   (w_cur_l),
    .bd_page    (RD_PAGE),
    .bd_col     (RD_COL),
    .bd_data    (w_bd_l)
  );

  lcd_ks_chip u_right (
    .CLK        (CLK),
    .RESET      (RESET),
    .panel_rst_n(LCD_RST),
    .op_valid   (w_valid_r),
    .op         (w_op),
    .wr_data    (r_din),
    .disp_on    (w_on_r),
    .start_line (w_unused_start_r),
    .cur_data   (w_cur_r),
    .bd_page    (RD_PAGE),
    .bd_col     (RD_COL),
    .bd_data    (w_bd_r)
  );

  // Read decision uses the live bus: it has been stable for the whole sync delay
  always_comb begin
    w_rd_byte = 8'h00;
    if (LCD_DI) w_rd_byte = LCD_CS1 ? w_cur_l : w_cur_r;
    else        w_rd_byte = status_byte(LCD_CS1 ? w_on_l : w_on_r, LCD_RST);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_dout    <= 8'h00;
      r_oe      <= 1'b0;
      r_rd_half <= 1'b0;
    end else begin
      r_rd_half <= RD_HALF;
      if (w_rise && LCD_RW && (LCD_CS1 || LCD_CS2)) begin
        r_dout <= w_rd_byte;
        r_oe   <= 1'b1;
      end else if (w_fall) begin
        r_oe <= 1'b0;
      end
    end
  end

  assign LCD_DATA_OUT = r_dout;
  assign LCD_DATA_OE  = r_oe;
  assign RD_DATA      = r_rd_half ? w_bd_r : w_bd_l;
  assign DISP_ON      = {w_on_r, w_on_l};

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_responder
// Description : Scoreboard bench for lcd_bus_responder (bus + backdoor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_responder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LCD_ENABLE = 1'b0, LCD_RW = 1'b0, LCD_DI = 1'b0;
  logic       LCD_CS1 = 1'b0, LCD_CS2 = 1'b0, LCD_RST = 1'b1;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;
  logic       RD_HALF = 1'b0;
  logic [2:0] RD_PAGE = 3'd0;
  logic [5:0] RD_COL = 6'd0;
  logic [7:0] RD_DATA;
  logic [1:0] DISP_ON;

  int n_cmp = 0;
  int n_err = 0;
  string      tag_q[$];
  logic [7:0] exp_q[$];

  lcd_bus_responder #(.SYNC_STAGES(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .LCD_ENABLE(LCD_ENABLE), .LCD_RW(LCD_RW),
    .LCD_DI(LCD_DI), .LCD_CS1(LCD_CS1), .LCD_CS2(LCD_CS2), .LCD_RST(LCD_RST),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT),
    .LCD_DATA_OE(LCD_DATA_OE), .RD_HALF(RD_HALF), .RD_PAGE(RD_PAGE),
    .RD_COL(RD_COL), .RD_DATA(RD_DATA), .DISP_ON(DISP_ON)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic bus_cmd(input logic cs1, input logic cs2, input logic di,
                         input logic [7:0] d);
    @(negedge CLK);
    LCD_CS1 = cs1; LCD_CS2 = cs2; LCD_RW = 1'b0; LCD_DI = di;
    LCD_DATA_IN = d; LCD_ENABLE = 1'b1;
    repeat (4) @(negedge CLK);
    LCD_ENABLE = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic bus_read(input logic cs1, input logic cs2, input logic di,
                          input logic [7:0] exp, input string tag);
    bit seen;
    @(negedge CLK);
    LCD_CS1 = cs1; LCD_CS2 = cs2; LCD_RW = 1'b1; LCD_DI = di; LCD_ENABLE = 1'b1;
    if (cs1 || cs2) begin
      tag_q.push_back(tag);
      exp_q.push_back(exp);
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge CLK);
      if (LCD_DATA_OE) seen = 1'b1;
    end
    if (cs1 || cs2) begin
      if (!seen) chk({tag, "_oe_timeout"}, 8'd0, 8'd1);
      chk(tag_q.pop_front(), LCD_DATA_OUT, exp_q.pop_front());
      repeat (2) @(negedge CLK);
      chk({tag, "_oe_hold"}, {7'd0, LCD_DATA_OE}, 8'd1);
    end else begin
      chk({tag, "_oe_none"}, {7'd0, seen}, 8'd0);
    end
    LCD_ENABLE = 1'b0;
    repeat (4) @(negedge CLK);
    chk({tag, "_oe_drop"}, {7'd0, LCD_DATA_OE}, 8'd0);
    LCD_RW = 1'b0;
  endtask

  task automatic bd_check(input logic half, input logic [2:0] page,
                          input logic [5:0] col, input logic [7:0] exp,
                          input string tag);
    @(negedge CLK);
    RD_HALF = half; RD_PAGE = page; RD_COL = col;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    chk(tag_q.pop_front(), RD_DATA, exp_q.pop_front());
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_disp_on", {6'd0, DISP_ON}, 8'h00);
    chk("rst_oe", {7'd0, LCD_DATA_OE}, 8'h00);
    chk("rst_dout", LCD_DATA_OUT, 8'h00);
    chk("rst_rd_data", RD_DATA, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Display on, left half: latency is exactly SYNC_STAGES+1 edges after fall
    LCD_CS1 = 1'b1; LCD_CS2 = 1'b0; LCD_RW = 1'b0; LCD_DI = 1'b0;
    LCD_DATA_IN = 8'h3F; LCD_ENABLE = 1'b1;
    repeat (4) @(negedge CLK);
    LCD_ENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("on_early", {6'd0, DISP_ON}, 8'h00);
    @(posedge CLK);
    #1 chk("on_latency", {6'd0, DISP_ON}, 8'h01);
    repeat (2) @(negedge CLK);

    // Left half page 2, Y 5, consecutive data writes
    bus_cmd(1, 0, 0, 8'hBA);
    bus_cmd(1, 0, 0, 8'h45);
    bus_cmd(1, 0, 1, 8'hAA);
    bus_cmd(1, 0, 1, 8'h55);
    bus_cmd(1, 0, 1, 8'h77);
    bd_check(0, 3'd2, 6'd5, 8'hAA, "bd_l_2_5");
    bd_check(0, 3'd2, 6'd6, 8'h55, "bd_l_2_6");
    bd_check(0, 3'd2, 6'd7, 8'h77, "bd_l_2_7_y");
    bus_cmd(1, 0, 0, 8'h45);
    bus_read(1, 0, 1, 8'hAA, "rd_l_y5");
    bus_read(1, 0, 1, 8'h55, "rd_l_y6_inc");

    // Right half Y wrap at 63
    bus_cmd(0, 1, 0, 8'hB8);
    bus_cmd(0, 1, 0, 8'h7F);
    bus_cmd(0, 1, 1, 8'h11);
    bus_cmd(0, 1, 1, 8'h22);
    bd_check(1, 3'd0, 6'd63, 8'h11, "bd_r_0_63");
    bd_check(1, 3'd0, 6'd0, 8'h22, "bd_r_0_0_wrap");

    // Both halves at once
    bus_cmd(1, 1, 0, 8'hBF);
    bus_cmd(1, 1, 0, 8'h40);
    bus_cmd(1, 1, 1, 8'hF8);
    bd_check(0, 3'd7, 6'd0, 8'hF8, "bd_l_7_0");
    bd_check(1, 3'd7, 6'd0, 8'hF8, "bd_r_7_0");
    bus_cmd(1, 1, 0, 8'h40);
    bus_read(1, 1, 1, 8'hF8, "rd_both");
    bus_read(0, 1, 0, 8'h20, "stat_r_off");
    bus_read(1, 0, 0, 8'h00, "stat_l_on");
    chk("disp_on_left_only", {6'd0, DISP_ON}, 8'h01);

    // Panel reset held low
    @(negedge CLK);
    LCD_RST = 1'b0;
    @(negedge CLK);
    chk("prst_disp_off", {6'd0, DISP_ON}, 8'h00);
    bus_read(1, 0, 0, 8'h30, "stat_in_prst");
    bus_cmd(1, 0, 0, 8'h3F);
    chk("prst_write_ignored", {6'd0, DISP_ON}, 8'h00);
    @(negedge CLK);
    LCD_RST = 1'b1;
    bus_read(1, 0, 0, 8'h20, "stat_after_prst");
    bd_check(0, 3'd2, 6'd5, 8'hAA, "bd_kept_after_prst");

    // No chip select
    bus_cmd(0, 0, 0, 8'h3F);
    chk("nocs_no_change", {6'd0, DISP_ON}, 8'h00);
    bus_read(0, 0, 1, 8'h00, "rd_nocs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for LCD_ENABLE and the bus inputs (minimum 2).
REQ-002 SHALL have CLK, input, 1: the single system clock; all logic is on the rising edge.
REQ-003 SHALL have RESET, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have LCD_ENABLE, input, 1: bus strobe; a command is latched on its falling edge.
REQ-005 SHALL have LCD_RW, input, 1: 1 = read, 0 = write.
REQ-006 SHALL have LCD_DI, input, 1: 1 = data, 0 = instruction/status.
REQ-007 SHALL have LCD_CS1 and LCD_CS2, input, 1 each: active-high selects; CS1 = left half (columns 0-63), CS2 = right half.
REQ-008 SHALL have LCD_RST, input, 1: panel reset, active-low, level-sensitive.
REQ-009 SHALL have LCD_DATA_IN, input, 8: the write bus.
REQ-010 SHALL have LCD_DATA_OUT, output, 8, and LCD_DATA_OE, output, 1: read data and its drive enable.
REQ-011 SHALL have RD_HALF, input, 1; RD_PAGE, input, 3; RD_COL, input, 6; RD_DATA, output, 8: a backdoor RAM read port, registered with 1-cycle latency.
REQ-012 SHALL have DISP_ON, output, 2: the display-on flag per half (bit0 = left).

Function
REQ-013 SHALL pass LCD_ENABLE through SYNC_STAGES flops; the other bus inputs SHALL be registered every cycle while the synchronized ENABLE is 1.
REQ-014 SHALL execute the captured command on the cycle a synchronized 1->0 transition of ENABLE is detected; latency is SYNC_STAGES+1 CLK cycles from the ENABLE fall.
REQ-015 SHALL hold, per half, the registers Y (6b), X page (3b), START (6b) and ON (1b), plus a RAM of 8 pages x 64 bytes.
REQ-016 SHALL decode writes with DI=0, RW=0 as follows; unlisted codes are ignored:
  - 0x3E/0x3F: ON=bit0.
  - 01yyyyyy: Y=y.
  - 10111ppp: X=p.
  - 11llllll: START=l.
REQ-017 SHALL handle a data write (DI=1, RW=0) as RAM[X][Y]=data, then Y=Y+1 modulo 64 (63 wraps to 0; X unchanged).
REQ-018 SHALL apply a command with both CS asserted to both halves independently; a command with neither asserted SHALL be ignored.
REQ-019 SHALL handle reads (RW=1) as follows:
  - On the synchronized 0->1 transition of ENABLE, register LCD_DATA_OUT and raise LCD_DATA_OE.
  - Keep OE until the synchronized ENABLE falls.
  - Read data is taken from the left half if CS1 is set, otherwise from the right half.
  - Neither CS asserted: OE stays 0.
REQ-020 SHALL return a status read (DI=0) as {busy=0, 0, OFF=~ON, RSTflag, 4'b0000}, where RSTflag=~LCD_RST.
REQ-021 SHALL return RAM[X][Y] on a data read (DI=1), then increment Y modulo 64 at the ENABLE fall (no dummy read).
REQ-022 SHALL ignore bus commands while LCD_RST=0 and force in both halves: ON=0, START=0, X=0, Y=0; RAM SHALL be preserved.
REQ-023 SHALL return RAM contents on RD_DATA independent of bus activity; a same-cycle write/backdoor collision returns the old data.

Reset
REQ-024 SHALL, while RESET=0 at a CLK edge, clear: the sync flops, the captured bus, Y/X/START/ON of both halves, LCD_DATA_OUT=0x00, LCD_DATA_OE=0, DISP_ON=2'b00 and RD_DATA=0x00.
REQ-025 SHALL leave RAM contents undefined after RESET; an ENABLE pulse in flight when RESET asserts SHALL be discarded.

Structure
REQ-026 SHALL place the following in a shared package: command opcode constants (DISP_ONOFF, SET_Y, SET_PAGE, SET_START), status bit positions, and the COLS=64 / PAGES=8 constants.
REQ-027 SHALL implement the per-half register and RAM state as sub-module lcd_ks_chip, instantiated twice; decoding, synchronization and the read mux SHALL reside in the top level.

Verification
REQ-028 SHALL verify: RESET low, then send 0x3F with CS1=1 -> DISP_ON=2'b01 exactly SYNC_STAGES+1 cycles after the ENABLE fall.
REQ-029 SHALL verify: CS1, 0xB8+2, 0x40+5, then data 0xAA, 0x55 -> backdoor (0,2,5)=0xAA, (0,2,6)=0x55, Y=7.
REQ-030 SHALL verify: CS2, Y=63, write 0x11 then 0x22 -> (1,0,63)=0x11, (1,0,0)=0x22 (wrap).
REQ-031 SHALL verify: CS1=CS2=1, write 0xF8 at page 7, Y=0 -> both halves hold 0xF8; a data read returns 0xF8 with OE high only while ENABLE is high.
REQ-032 SHALL verify: LCD_RST=0 -> a status read returns 0x30; a write of 0x3F is ignored; after LCD_RST=1, a status read returns 0x20 and prior RAM is intact.
REQ-033 SHALL verify: CS1=CS2=0, write 0x3F -> no state change and OE stays 0 on a read.
